ex_muldiv: RTL and testbench

//  Parametrised multi-cycle RV M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) for the EX stage.

---
 rtl/ex_muldiv.sv | 179 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) for EX.
// Multiply completes in MUL_STAGES cycles; divide is restoring, DIV_BITS quotient bits per cycle.
module ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int DIV_BITS   = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_f3,
    output logic [XLEN-1:0] o_res,
    output logic            o_done,
    output logic            o_busy,
    output logic            o_stall
);
    localparam int DIV_STEPS = XLEN / DIV_BITS;
    localparam int CNT_MAX   = (MUL_STAGES > DIV_STEPS) ? MUL_STAGES : DIV_STEPS;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int PW        = 2 * XLEN;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  res_d;
    logic [XLEN-1:0]  a_q, b_q, rem_q, quo_q;
    logic [2:0]       f3_q;
    logic             q_neg_q, r_neg_q;

    // Decode of the live inputs, only meaningful in the accept cycle.
    logic            accept, in_div, in_sgn, in_rem;
    logic            rs1_neg, rs2_neg, div_zero, div_ovf;
    logic [XLEN-1:0] rs1_abs, rs2_abs, spec_res;

    assign accept   = (state_q == S_IDLE) && i_en && !i_flush;
    assign in_div   = i_f3[2];
    assign in_sgn   = i_f3[2] && !i_f3[0];
    assign in_rem   = i_f3[1];
    assign rs1_neg  = in_sgn && i_rs1[XLEN-1];
    assign rs2_neg  = in_sgn && i_rs2[XLEN-1];
    assign rs1_abs  = rs1_neg ? -i_rs1 : i_rs1;
    assign rs2_abs  = rs2_neg ? -i_rs2 : i_rs2;
    assign div_zero = (i_rs2 == '0);
    assign div_ovf  = in_sgn && (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == '1);
    assign spec_res = div_zero ? (in_rem ? i_rs1 : '1) : (in_rem ? '0 : i_rs1);

    // Multiplier: one extra sign bit per operand covers s*s, s*u and u*u.
    logic [XLEN-1:0]      mul_a, mul_b, mul_res;
    logic [2:0]           mul_f3;
    logic signed [XLEN:0] mul_sa, mul_sb;
    logic signed [PW-1:0] mul_prod;

    assign mul_a    = (state_q == S_IDLE) ? i_rs1 : a_q;
    assign mul_b    = (state_q == S_IDLE) ? i_rs2 : b_q;
    assign mul_f3   = (state_q == S_IDLE) ? i_f3  : f3_q;
    assign mul_sa   = {((mul_f3 == 3'd1) || (mul_f3 == 3'd2)) && mul_a[XLEN-1], mul_a};
    assign mul_sb   = {(mul_f3 == 3'd1) && mul_b[XLEN-1], mul_b};
    assign mul_prod = PW'(mul_sa) * PW'(mul_sb);
    assign mul_res  = (mul_f3 == 3'd0) ? mul_prod[XLEN-1:0] : mul_prod[PW-1:XLEN];

    // Divider step. The first DIV_BITS digits are retired on the accept edge itself,
    // so DIV needs only DIV_STEPS-1 cycles and FIX still fits in the quoted latency.
    logic [XLEN-1:0] st_rem_in, st_quo_in, st_dvs, st_rem, st_quo, fix_res;
    logic [XLEN:0]   st_trial;

    assign st_rem_in = (state_q == S_IDLE) ? '0      : rem_q;
    assign st_quo_in = (state_q == S_IDLE) ? rs1_abs : quo_q;
    assign st_dvs    = (state_q == S_IDLE) ? rs2_abs : b_q;

    // NOTE: combinational blocks use blocking '=' so each loop pass sees the previous one;
    // clocked state below uses non-blocking '<=' only.
    always_comb begin
        st_rem   = st_rem_in;
        st_quo   = st_quo_in;
        st_trial = '0;
        for (int k = 0; k < DIV_BITS; k++) begin
            st_trial = {st_rem, st_quo[XLEN-1]} - {1'b0, st_dvs};
            if (!st_trial[XLEN]) begin
                st_rem = st_trial[XLEN-1:0];
                st_quo = {st_quo[XLEN-2:0], 1'b1};
            end else begin
                st_rem = {st_rem[XLEN-2:0], st_quo[XLEN-1]};
                st_quo = {st_quo[XLEN-2:0], 1'b0};
            end
        end
    end

    assign fix_res = f3_q[1] ? (r_neg_q ? -rem_q : rem_q) : (q_neg_q ? -quo_q : quo_q);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = o_res;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!in_div) begin
                        if (MUL_STAGES == 1) begin
                            state_d = S_DONE;
                            res_d   = mul_res;
                        end else begin
                            state_d = S_MUL;
                            cnt_d   = CNT_W'(MUL_STAGES - 2);
                        end
                    end else if (div_zero || div_ovf) begin
                        state_d = S_DONE;
                        res_d   = spec_res;
                    end else begin
                        state_d = S_DIV;
                        cnt_d   = CNT_W'(DIV_STEPS - 2);
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    res_d   = mul_res;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV: begin
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FIX: begin
                state_d = S_DONE;
                res_d   = fix_res;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A kill wins over everything, including the result write.
        if (i_flush) begin
            state_d = S_IDLE;
            res_d   = o_res;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            o_res   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            f3_q    <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_res   <= res_d;
            if (accept) begin
                a_q     <= i_rs1;
                b_q     <= in_div ? rs2_abs : i_rs2;
                f3_q    <= i_f3;
                q_neg_q <= rs1_neg ^ rs2_neg;
                r_neg_q <= rs1_neg;
            end
            if (accept || (state_q == S_DIV)) begin
                rem_q <= st_rem;
                quo_q <= st_quo;
            end
        end
    end

    assign o_done  = (state_q == S_DONE);
    assign o_busy  = (state_q != S_IDLE);
    assign o_stall = i_en && !o_done;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed vectors push expectations, monitors pop on o_done.
// A second instance with DIV_BITS=4 covers the higher-radix divider latency.
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, flush;
    logic [31:0] rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] res;
    logic        done, busy, stall;

    logic        en4, flush4;
    logic [31:0] rs1_4, rs2_4;
    logic [2:0]  f3_4;
    logic [31:0] res4;
    logic        done4, busy4, stall4;

    ex_muldiv #(.XLEN(32), .MUL_STAGES(2), .DIV_BITS(1)) u_dut (
        .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_flush(flush),
        .i_rs1(rs1), .i_rs2(rs2), .i_f3(f3),
        .o_res(res), .o_done(done), .o_busy(busy), .o_stall(stall)
    );

    ex_muldiv #(.XLEN(32), .MUL_STAGES(2), .DIV_BITS(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst_n), .i_en(en4), .i_flush(flush4),
        .i_rs1(rs1_4), .i_rs2(rs2_4), .i_f3(f3_4),
        .o_res(res4), .o_done(done4), .o_busy(busy4), .o_stall(stall4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       nm;
        logic [31:0] res;
        int          at;
    } exp_t;

    typedef struct {
        string       nm;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;

    exp_t        sb[$];
    exp_t        sb4[$];
    vec_t        vecs[$];
    logic [31:0] last_res;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", done, 1'b0);
            end else begin
                e = sb.pop_front();
                check(e.nm, res, e.res);
                check({e.nm, "_cycle"}, cyc, e.at);
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (rst_n && done4) begin
            if (sb4.size() == 0) begin
                check("spurious_done4", done4, 1'b0);
            end else begin
                e = sb4.pop_front();
                check(e.nm, res4, e.res);
                check({e.nm, "_cycle"}, cyc, e.at);
            end
        end
    end

    // Called on a negedge. delay = idle cycles before the DUT can accept (1 right after DONE).
    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r, input int lat,
                          input int delay, input bit keep_en);
        bit got;
        bit stall_ok;
        got      = 1'b0;
        stall_ok = 1'b1;
        f3  = f;
        rs1 = a;
        rs2 = b;
        en  = 1'b1;
        sb.push_back('{nm, r, cyc + delay + lat});
        for (int i = 0; i < lat + delay + 5 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                if (stall) stall_ok = 1'b0;
            end else if (!stall) begin
                stall_ok = 1'b0;
            end
            if (i == delay && !keep_en) begin
                rs1 = ~a;
                rs2 = ~b;
                f3  = ~f;
            end
        end
        check({nm, "_done_seen"}, got, 1'b1);
        check({nm, "_stall"}, stall_ok, 1'b1);
        last_res = r;
        if (!keep_en) begin
            en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic run4(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r, input int lat);
        bit got;
        got   = 1'b0;
        f3_4  = f;
        rs1_4 = a;
        rs2_4 = b;
        en4   = 1'b1;
        sb4.push_back('{nm, r, cyc + lat});
        for (int i = 0; i < lat + 5 && !got; i++) begin
            @(negedge clk);
            if (done4) got = 1'b1;
        end
        check({nm, "_done_seen"}, got, 1'b1);
        en4 = 1'b0;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; rs1 = '0; rs2 = '0; f3 = '0;
        en4 = 1'b0; flush4 = 1'b0; rs1_4 = '0; rs2_4 = '0; f3_4 = '0;
        last_res = '0;

        vecs.push_back('{"mul_7xm3",     3'd0, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2});
        vecs.push_back('{"mulh_min",     3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 2});
        vecs.push_back('{"mulhu_max",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2});
        vecs.push_back('{"mulhsu_m1x2",  3'd2, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 2});
        vecs.push_back('{"mulh_m1xm1",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        2});
        vecs.push_back('{"mul_shift",    3'd0, 32'h12345678, 32'h10,       32'h23456780, 2});
        vecs.push_back('{"divu_100_7",   3'd5, 32'd100,      32'd7,        32'd14,       33});
        vecs.push_back('{"remu_100_7",   3'd7, 32'd100,      32'd7,        32'd2,        33});
        vecs.push_back('{"rem_m7_2",     3'd6, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 33});
        vecs.push_back('{"div_m7_2",     3'd4, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 33});
        vecs.push_back('{"div_7_m2",     3'd4, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33});
        vecs.push_back('{"rem_7_m2",     3'd6, 32'h7,        32'hFFFFFFFE, 32'h1,        33});
        vecs.push_back('{"divu_max_3",   3'd5, 32'hFFFFFFFF, 32'h3,        32'h55555555, 33});
        vecs.push_back('{"div_by0",      3'd4, 32'h5,        32'h0,        32'hFFFFFFFF, 1});
        vecs.push_back('{"divu_by0",     3'd5, 32'h5,        32'h0,        32'hFFFFFFFF, 1});
        vecs.push_back('{"div_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{"rem_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1});
        vecs.push_back('{"remu_by0",     3'd7, 32'h1234,     32'h0,        32'h1234,     1});

        repeat (2) @(negedge clk);
        check("rst_res",   res,  32'h0);
        check("rst_done",  done, 1'b0);
        check("rst_busy",  busy, 1'b0);
        check("rst_stall", stall, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_op(vecs[i].nm, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat, 0, 1'b0);

        // Kill a divide at T+5; the result must hold and a new multiply must run cleanly.
        f3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; en = 1'b1;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", busy, 1'b0);
        check("flush_res_hold", res, last_res);
        run_op("mul_after_flush", 3'd0, 32'd9, 32'd11, 32'd99, 2, 0, 1'b0);

        // Asynchronous reset in the middle of a divide.
        f3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd7; en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_res",  res,  32'h0);
        check("midrst_done", done, 1'b0);
        check("midrst_busy", busy, 1'b0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("b2b_first",  3'd0, 32'd3, 32'd4, 32'd12, 2, 0, 1'b1);
        run_op("b2b_second", 3'd0, 32'd5, 32'd6, 32'd30, 2, 1, 1'b0);

        run4("r4_divu_100_7", 3'd5, 32'd100,      32'd7,  32'd14,       9);
        run4("r4_div_m7_2",   3'd4, 32'hFFFFFFF9, 32'h2,  32'hFFFFFFFD, 9);
        run4("r4_rem_m7_2",   3'd6, 32'hFFFFFFF9, 32'h2,  32'hFFFFFFFF, 9);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size() + sb4.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
